// File: rtl/timer_counter_dev.sv
// Memory-mapped 32-bit down-counting timer behind the TC bridge window.
// CTRL/PRESET are CPU-writable, COUNT is read-only, and IRQ is a level output gated by CTRL.IM.
module timer_counter_dev #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              We,
  input  logic [1:0]        Addr,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD,
  output logic              IRQ
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_AUTO   = 2'b01;

  localparam logic [DATA_W-1:0] CNT_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  tc_state_e         state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic              en_q, en_d;
  logic [1:0]        mode_q, mode_d;
  logic              im_q, im_d;
  logic              irq_pending_q, irq_pending_d;
  logic              irq_pulse_q, irq_pulse_d;

  logic              ctrl_wr;
  logic              preset_wr;
  logic              int_fire;
  logic              auto_mode;

  assign ctrl_wr   = We && (Addr == ADDR_CTRL);
  assign preset_wr = We && (Addr == ADDR_PRESET);
  assign auto_mode = (mode_q == MODE_AUTO);

  // Counter FSM: the reload always passes through IDLE -> LOAD, which gives the N+3 period.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    int_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q <= CNT_ONE) begin
          count_d = CNT_ZERO;
          state_d = ST_INT;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      ST_INT: begin
        int_fire = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A CPU CTRL write overrides the one-shot Enable clear that happens on the same edge.
  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    im_d   = im_q;
    if (int_fire && !auto_mode) en_d = 1'b0;
    if (ctrl_wr) begin
      en_d   = WD[0];
      mode_d = WD[2:1];
      im_d   = WD[3];
    end
  end

  always_comb begin
    preset_d = preset_q;
    if (preset_wr) preset_d = WD;
  end

  // Expiry sets pending even when a CTRL write lands on the same edge.
  always_comb begin
    irq_pending_d = irq_pending_q;
    irq_pulse_d   = irq_pulse_q;
    if (irq_pulse_q) begin
      irq_pending_d = 1'b0;
      irq_pulse_d   = 1'b0;
    end
    if (ctrl_wr) begin
      irq_pending_d = 1'b0;
      irq_pulse_d   = 1'b0;
    end
    if (int_fire) begin
      irq_pending_d = 1'b1;
      irq_pulse_d   = auto_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      preset_q      <= '0;
      en_q          <= 1'b0;
      mode_q        <= 2'b00;
      im_q          <= 1'b0;
      irq_pending_q <= 1'b0;
      irq_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      preset_q      <= preset_d;
      en_q          <= en_d;
      mode_q        <= mode_d;
      im_q          <= im_d;
      irq_pending_q <= irq_pending_d;
      irq_pulse_q   <= irq_pulse_d;
    end
  end

  always_comb begin
    RD = '0;
    case (Addr)
      ADDR_CTRL:   RD = {{(DATA_W-4){1'b0}}, im_q, mode_q, en_q};
      ADDR_PRESET: RD = preset_q;
      ADDR_COUNT:  RD = count_q;
      default:     RD = '0;
    endcase
  end

  assign IRQ = irq_pending_q & im_q;

endmodule

// File: tb/tb_timer_counter_dev.sv
// Self-checking bench for timer_counter_dev: register access, one-shot, auto-reload,
// masking, pause/reload, write/expiry collision and mid-count reset.
module tb_timer_counter_dev;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         We;
  logic [1:0]   Addr;
  logic [W-1:0] WD;
  logic [W-1:0] RD;
  logic         IRQ;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           failures;
  logic [W-1:0] rd_val;

  timer_counter_dev #(.DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .We    (We),
    .Addr  (Addr),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Checker and scoreboard
  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      check_val({tag, "_underflow"}, got, ~got);
    end else begin
      check_val(tag, got, exp_q.pop_front());
    end
  endtask

  // Driver tasks: all activity lands 1ns after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [W-1:0] d);
    We   = 1'b1;
    Addr = a;
    WD   = d;
    step();
    We   = 1'b0;
    WD   = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [W-1:0] d);
    Addr = a;
    #1;
    d = RD;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    We       = 1'b0;
    Addr     = 2'd0;
    WD       = '0;
    step_n(2);
    reset = 1'b0;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rd_reg(a[1:0], rd_val);
      check_val($sformatf("reset_rd%0d", a), rd_val, '0);
    end
    check_val("reset_irq", {31'b0, IRQ}, 0);
    step();

    // One-shot, IM=1, PRESET=5: COUNT 5..0 at t+2..t+7, IRQ from t+8
    cpu_write(2'd1, 32'd5);
    cpu_write(2'd0, 32'h9);
    for (int v = 5; v >= 0; v--) sb_push(v);
    step();
    for (int k = 2; k <= 7; k++) begin
      step();
      rd_reg(2'd2, rd_val);
      sb_check($sformatf("oneshot_count_t%0d", k), rd_val);
    end
    check_val("oneshot_irq_t7", {31'b0, IRQ}, 0);
    step();
    check_val("oneshot_irq_t8", {31'b0, IRQ}, 1);
    step_n(3);
    check_val("oneshot_irq_held", {31'b0, IRQ}, 1);
    rd_reg(2'd0, rd_val);
    check_val("oneshot_ctrl", rd_val, 32'h8);
    cpu_write(2'd0, 32'h8);
    check_val("oneshot_irq_clear", {31'b0, IRQ}, 0);

    // Auto-reload, PRESET=5: one-cycle pulses at t+8, t+16, t+24
    cpu_write(2'd0, 32'hB);
    for (int k = 1; k <= 24; k++) sb_push((k % 8 == 0) ? 1 : 0);
    for (int k = 1; k <= 24; k++) begin
      step();
      sb_check($sformatf("auto_irq_t%0d", k), {31'b0, IRQ});
    end
    rd_reg(2'd0, rd_val);
    check_val("auto_ctrl", rd_val, 32'hB);
    cpu_write(2'd0, 32'h0);
    step_n(4);

    // Masked one-shot, PRESET=3
    cpu_write(2'd1, 32'd3);
    cpu_write(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_val($sformatf("mask_irq_t%0d", k), {31'b0, IRQ}, 0);
    end
    rd_reg(2'd2, rd_val);
    check_val("mask_count", rd_val, 0);
    rd_reg(2'd0, rd_val);
    check_val("mask_ctrl", rd_val, 0);
    cpu_write(2'd0, 32'h8);
    step_n(2);
    check_val("mask_im_set_irq", {31'b0, IRQ}, 0);
    cpu_write(2'd0, 32'h0);

    // Pause at COUNT=3, register access, re-enable reloads PRESET
    cpu_write(2'd1, 32'd6);
    cpu_write(2'd0, 32'h1);
    step_n(4);
    rd_reg(2'd2, rd_val);
    check_val("pause_count_before", rd_val, 4);
    cpu_write(2'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      rd_reg(2'd2, rd_val);
      check_val($sformatf("pause_hold%0d", k), rd_val, 3);
    end
    cpu_write(2'd2, 32'hFFFF);
    rd_reg(2'd2, rd_val);
    check_val("count_ro", rd_val, 3);
    cpu_write(2'd3, 32'hFFFF_FFFF);
    rd_reg(2'd3, rd_val);
    check_val("addr3_zero", rd_val, 0);
    cpu_write(2'd0, 32'hFFFF_FFFF);
    rd_reg(2'd0, rd_val);
    check_val("ctrl_mask_bits", rd_val, 32'hF);
    step_n(2);
    rd_reg(2'd2, rd_val);
    check_val("reenable_reload", rd_val, 6);
    step_n(6);
    check_val("mode3_irq_early", {31'b0, IRQ}, 0);
    step();
    check_val("mode3_irq", {31'b0, IRQ}, 1);
    rd_reg(2'd0, rd_val);
    check_val("mode3_ctrl", rd_val, 32'hE);
    cpu_write(2'd0, 32'h0);
    check_val("mode3_irq_clear", {31'b0, IRQ}, 0);

    // Collision: CTRL write on the INT edge keeps Enable, pending still set
    cpu_write(2'd1, 32'd1);
    cpu_write(2'd0, 32'h9);
    step_n(3);
    rd_reg(2'd2, rd_val);
    check_val("coll_count_zero", rd_val, 0);
    cpu_write(2'd0, 32'h9);
    check_val("coll_irq", {31'b0, IRQ}, 1);
    rd_reg(2'd0, rd_val);
    check_val("coll_ctrl", rd_val, 32'h9);
    step_n(2);
    rd_reg(2'd2, rd_val);
    check_val("coll_second_load", rd_val, 1);
    cpu_write(2'd0, 32'h0);
    step_n(4);

    // Reset mid-count
    cpu_write(2'd1, 32'd9);
    cpu_write(2'd0, 32'h9);
    step_n(5);
    rd_reg(2'd2, rd_val);
    check_val("rst_mid_count", rd_val, 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_reg(2'd2, rd_val);
    check_val("rst_count", rd_val, 0);
    rd_reg(2'd0, rd_val);
    check_val("rst_ctrl", rd_val, 0);
    rd_reg(2'd1, rd_val);
    check_val("rst_preset", rd_val, 0);
    check_val("rst_irq", {31'b0, IRQ}, 0);
    step_n(15);
    check_val("rst_irq_later", {31'b0, IRQ}, 0);
    rd_reg(2'd2, rd_val);
    check_val("rst_count_later", rd_val, 0);

    if (exp_q.size() != 0) check_val("sb_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
